// File: rtl/uart_rx_if.sv
// ============================================================================
// Module   : uart_rx_if
// Brief    : Serial line and parallel byte handshake bundle for uart_rx.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;

  modport slave (
    input  rx,
    input  rx_ready,
    output rx_data,
    output rx_valid,
    output rx_frame_err,
    output rx_overrun,
    output rx_busy
  );

  modport master (
    output rx,
    output rx_ready,
    input  rx_data,
    input  rx_valid,
    input  rx_frame_err,
    input  rx_overrun,
    input  rx_busy
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver, mid-bit sampling, framing/overrun flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  wire          clk,
  input  wire          rst_n,
  uart_rx_if.slave     bus
);

  localparam int          c_CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int          c_HALF         = c_CLKS_PER_BIT / 2;
  localparam logic [15:0] c_BIT_LAST     = 16'(c_CLKS_PER_BIT - 1);
  localparam logic [15:0] c_HALF_LAST    = 16'(c_HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START_BIT = 3'd1,
    S_DATA_BITS = 3'd2,
    S_STOP_BIT  = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] clk_count_q, clk_count_d;
  logic [2:0]  bit_index_q, bit_index_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        pending_q, pending_d;
  logic        overrun_q, overrun_d;
  logic        meta_q, rx_s_q;
  logic        w_good;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      clk_count_q <= '0;
      bit_index_q <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      meta_q      <= 1'b1;
      rx_s_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      clk_count_q <= clk_count_d;
      bit_index_q <= bit_index_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      meta_q      <= bus.rx;
      rx_s_q      <= meta_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    clk_count_d = clk_count_q;
    bit_index_d = bit_index_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    ferr_d      = 1'b0;
    pending_d   = pending_q;
    overrun_d   = overrun_q;
    w_good      = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_count_d = '0;
        bit_index_d = '0;
        if (!rx_s_q) state_d = S_START_BIT;
      end
      S_START_BIT: begin
        if (clk_count_q == c_HALF_LAST) begin
          clk_count_d = '0;
          // A start bit that has gone high again by mid-bit is line noise
          state_d     = rx_s_q ? S_IDLE : S_DATA_BITS;
        end else begin
          clk_count_d = clk_count_q + 16'd1;
        end
      end
      S_DATA_BITS: begin
        if (clk_count_q == c_BIT_LAST) begin
          clk_count_d          = '0;
          shift_d[bit_index_q] = rx_s_q;
          if (bit_index_q == 3'd7) begin
            bit_index_d = '0;
            state_d     = S_STOP_BIT;
          end else begin
            bit_index_d = bit_index_q + 3'd1;
          end
        end else begin
          clk_count_d = clk_count_q + 16'd1;
        end
      end
      S_STOP_BIT: begin
        if (clk_count_q == c_BIT_LAST) begin
          clk_count_d = '0;
          if (rx_s_q) begin
            w_good  = 1'b1;
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end else begin
          clk_count_d = clk_count_q + 16'd1;
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        clk_count_d = '0;
        bit_index_d = '0;
      end
    endcase

    if (w_good) begin
      pending_d = 1'b1;
      if (pending_q && !bus.rx_ready) overrun_d = 1'b1;
    end else if (bus.rx_ready) begin
      pending_d = 1'b0;
    end
  end

  assign bus.rx_data      = data_q;
  assign bus.rx_valid     = valid_q;
  assign bus.rx_frame_err = ferr_q;
  assign bus.rx_overrun   = overrun_q;
  assign bus.rx_busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed self-checking bench for uart_rx at 10 clocks per bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  int         n_valid;
  int         n_ferr;
  int         n_both;
  logic [7:0] log_mem [0:63];

  uart_rx_if u_if ();

  uart_rx #(
    .CLK_FREQ  (1000000),
    .BAUD_RATE (100000)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monotonic event counters; tasks compare deltas against snapshots
  initial begin
    n_valid = 0;
    n_ferr  = 0;
    n_both  = 0;
  end

  always @(negedge clk) begin
    if (u_if.rx_valid === 1'b1) begin
      log_mem[n_valid % 64] <= u_if.rx_data;
      n_valid               <= n_valid + 1;
    end
    if (u_if.rx_frame_err === 1'b1) n_ferr <= n_ferr + 1;
    if (u_if.rx_valid === 1'b1 && u_if.rx_frame_err === 1'b1) n_both <= n_both + 1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    u_if.rx = 1'b0;
    wait_clks(10);
    for (int i = 0; i < 8; i++) begin
      u_if.rx = d[i];
      wait_clks(10);
    end
    u_if.rx = stop;
    wait_clks(10);
    u_if.rx = 1'b1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    u_if.rx      = 1'b1;
    u_if.rx_ready = 1'b1;
    wait_clks(3);
    total++; if (u_if.rx_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", u_if.rx_data); else passed++;
    total++; if (u_if.rx_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", u_if.rx_valid); else passed++;
    total++; if (u_if.rx_frame_err !== 1'b0) $display("FAIL reset_ferr got=%b exp=0", u_if.rx_frame_err); else passed++;
    total++; if (u_if.rx_overrun !== 1'b0) $display("FAIL reset_overrun got=%b exp=0", u_if.rx_overrun); else passed++;
    total++; if (u_if.rx_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", u_if.rx_busy); else passed++;
    rst_n = 1'b1;
    wait_clks(5);
  endtask

  task automatic test_single();
    int v0, f0;
    v0 = n_valid;
    f0 = n_ferr;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_clks(30);
        total++; if (u_if.rx_busy !== 1'b1) $display("FAIL single_busy_mid got=%b exp=1", u_if.rx_busy); else passed++;
      end
    join
    wait_clks(5);
    total++; if (n_valid - v0 !== 1) $display("FAIL single_valid_cnt got=%0d exp=1", n_valid - v0); else passed++;
    total++; if (u_if.rx_data !== 8'hA5) $display("FAIL single_data got=%h exp=a5", u_if.rx_data); else passed++;
    total++; if (n_ferr - f0 !== 0) $display("FAIL single_ferr_cnt got=%0d exp=0", n_ferr - f0); else passed++;
    total++; if (u_if.rx_busy !== 1'b0) $display("FAIL single_busy_end got=%b exp=0", u_if.rx_busy); else passed++;
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = n_valid;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    wait_clks(10);
    total++; if (n_valid - v0 !== 3) $display("FAIL b2b_valid_cnt got=%0d exp=3", n_valid - v0); else passed++;
    total++; if (log_mem[v0 % 64] !== 8'h00) $display("FAIL b2b_byte0 got=%h exp=00", log_mem[v0 % 64]); else passed++;
    total++; if (log_mem[(v0 + 1) % 64] !== 8'hFF) $display("FAIL b2b_byte1 got=%h exp=ff", log_mem[(v0 + 1) % 64]); else passed++;
    total++; if (log_mem[(v0 + 2) % 64] !== 8'h3C) $display("FAIL b2b_byte2 got=%h exp=3c", log_mem[(v0 + 2) % 64]); else passed++;
  endtask

  task automatic test_frame_err();
    int v0, f0;
    v0 = n_valid;
    f0 = n_ferr;
    send_frame(8'h55, 1'b0);
    wait_clks(10);
    total++; if (n_ferr - f0 !== 1) $display("FAIL ferr_cnt got=%0d exp=1", n_ferr - f0); else passed++;
    total++; if (n_valid - v0 !== 0) $display("FAIL ferr_valid_cnt got=%0d exp=0", n_valid - v0); else passed++;
    total++; if (u_if.rx_data !== 8'h3C) $display("FAIL ferr_data_kept got=%h exp=3c", u_if.rx_data); else passed++;
    total++; if (u_if.rx_busy !== 1'b0) $display("FAIL ferr_busy_end got=%b exp=0", u_if.rx_busy); else passed++;
  endtask

  task automatic test_glitch();
    int v0, f0;
    v0 = n_valid;
    f0 = n_ferr;
    u_if.rx = 1'b0;
    wait_clks(3);
    u_if.rx = 1'b1;
    wait_clks(2);
    total++; if (u_if.rx_busy !== 1'b1) $display("FAIL glitch_busy_seen got=%b exp=1", u_if.rx_busy); else passed++;
    wait_clks(20);
    total++; if (n_valid - v0 !== 0) $display("FAIL glitch_valid_cnt got=%0d exp=0", n_valid - v0); else passed++;
    total++; if (n_ferr - f0 !== 0) $display("FAIL glitch_ferr_cnt got=%0d exp=0", n_ferr - f0); else passed++;
    total++; if (u_if.rx_busy !== 1'b0) $display("FAIL glitch_busy_end got=%b exp=0", u_if.rx_busy); else passed++;
  endtask

  task automatic test_overrun();
    int v0;
    v0 = n_valid;
    u_if.rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    wait_clks(3);
    total++; if (u_if.rx_overrun !== 1'b0) $display("FAIL ovr_first got=%b exp=0", u_if.rx_overrun); else passed++;
    send_frame(8'h22, 1'b1);
    wait_clks(3);
    total++; if (n_valid - v0 !== 2) $display("FAIL ovr_valid_cnt got=%0d exp=2", n_valid - v0); else passed++;
    total++; if (u_if.rx_data !== 8'h22) $display("FAIL ovr_data got=%h exp=22", u_if.rx_data); else passed++;
    total++; if (u_if.rx_overrun !== 1'b1) $display("FAIL ovr_set got=%b exp=1", u_if.rx_overrun); else passed++;
    u_if.rx_ready = 1'b1;
    wait_clks(5);
    total++; if (u_if.rx_overrun !== 1'b1) $display("FAIL ovr_sticky got=%b exp=1", u_if.rx_overrun); else passed++;
  endtask

  task automatic test_reset_midframe();
    int v0, f0;
    u_if.rx = 1'b0;
    wait_clks(10);
    for (int i = 0; i < 4; i++) begin
      u_if.rx = 1'b1;
      wait_clks(10);
    end
    u_if.rx = 1'b0;
    wait_clks(5);
    total++; if (u_if.rx_busy !== 1'b1) $display("FAIL mid_busy_before got=%b exp=1", u_if.rx_busy); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (u_if.rx_busy !== 1'b0) $display("FAIL mid_rst_busy got=%b exp=0", u_if.rx_busy); else passed++;
    total++; if (u_if.rx_data !== 8'h00) $display("FAIL mid_rst_data got=%h exp=00", u_if.rx_data); else passed++;
    total++; if (u_if.rx_overrun !== 1'b0) $display("FAIL mid_rst_overrun got=%b exp=0", u_if.rx_overrun); else passed++;
    total++; if (u_if.rx_valid !== 1'b0 || u_if.rx_frame_err !== 1'b0)
      $display("FAIL mid_rst_pulses got=%b%b exp=00", u_if.rx_valid, u_if.rx_frame_err); else passed++;
    u_if.rx = 1'b1;
    v0 = n_valid;
    f0 = n_ferr;
    wait_clks(5);
    rst_n = 1'b1;
    wait_clks(60);
    total++; if (n_valid - v0 !== 0 || n_ferr - f0 !== 0)
      $display("FAIL mid_no_pulses got=%0d/%0d exp=0/0", n_valid - v0, n_ferr - f0); else passed++;
    v0 = n_valid;
    send_frame(8'h96, 1'b1);
    wait_clks(5);
    total++; if (n_valid - v0 !== 1) $display("FAIL mid_next_cnt got=%0d exp=1", n_valid - v0); else passed++;
    total++; if (u_if.rx_data !== 8'h96) $display("FAIL mid_next_data got=%h exp=96", u_if.rx_data); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b1;
    u_if.rx = 1'b1;
    u_if.rx_ready = 1'b1;
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_overrun();
    test_reset_midframe();
    total++; if (n_both !== 0) $display("FAIL valid_and_ferr_together got=%0d exp=0", n_both); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
